// File: rtl/seq_mult_param_if.sv
// seq_mult_param_if: operand/result handshake bundle for the iterative multiplier.
interface seq_mult_param_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0]   a_bi;
  logic [WIDTH-1:0]   b_bi;
  logic [1:0]         mode_i;
  logic               start_i;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] y_bo;
  modport master(output a_bi, b_bi, mode_i, start_i, input busy_o, done_o, y_bo);
  modport slave(input a_bi, b_bi, mode_i, start_i, output busy_o, done_o, y_bo);
endinterface

// File: rtl/seq_mult_param.sv
// seq_mult_param: shift-add multiplier, one multiplier bit per clock; unsigned, sign-magnitude or two's complement.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  seq_mult_param_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, WORK} state_t;
  state_t           state;
  logic [CW-1:0]    ctr;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    ma;
  logic [WIDTH-1:0] mb;
  logic             sign;
  logic             sm;
  logic             tc;
  logic             sm_in;
  logic             tc_in;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [W2-1:0]    acc_nxt;
  logic [W2-1:0]    prod_y;
  // Multiplicand shifts left and multiplier shifts right, so no variable shifters are needed.
  always_comb begin
    sm_in   = bus.mode_i == 2'b01;
    tc_in   = bus.mode_i == 2'b10;
    mag_a   = sm_in ? {1'b0, bus.a_bi[WIDTH-2:0]} : (tc_in && bus.a_bi[WIDTH-1]) ? -bus.a_bi : bus.a_bi;
    mag_b   = sm_in ? {1'b0, bus.b_bi[WIDTH-2:0]} : (tc_in && bus.b_bi[WIDTH-1]) ? -bus.b_bi : bus.b_bi;
    acc_nxt = acc + (mb[0] ? ma : '0);
    prod_y  = sm ? {(sign && (acc_nxt != '0)), 1'b0, acc_nxt[W2-3:0]} : (tc && sign) ? -acc_nxt : acc_nxt;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      ctr        <= '0;
      acc        <= '0;
      ma         <= '0;
      mb         <= '0;
      sign       <= 1'b0;
      sm         <= 1'b0;
      tc         <= 1'b0;
      bus.busy_o <= 1'b0;
      bus.done_o <= 1'b0;
      bus.y_bo   <= '0;
    end else begin
      bus.done_o <= 1'b0;
      if (state == IDLE) begin
        if (bus.start_i) begin
          ma         <= W2'(mag_a);
          mb         <= mag_b;
          sign       <= (sm_in || tc_in) && (bus.a_bi[WIDTH-1] ^ bus.b_bi[WIDTH-1]);
          sm         <= sm_in;
          tc         <= tc_in;
          acc        <= '0;
          ctr        <= '0;
          bus.busy_o <= 1'b1;
          state      <= WORK;
        end
      end else begin
        acc <= acc_nxt;
        ma  <= ma << 1;
        mb  <= mb >> 1;
        ctr <= ctr + 1'b1;
        if (ctr == CW'(WIDTH - 1)) begin
          bus.y_bo   <= prod_y;
          bus.done_o <= 1'b1;
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed and randomised checks of seq_mult_param at WIDTH 4, 8 and 16.
module tb_seq_mult_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seq_mult_param_if #(4)  i4 ();
  seq_mult_param_if #(8)  i8 ();
  seq_mult_param_if #(16) i16 ();
  seq_mult_param #(.WIDTH(4))  d4  (.clk_i(clk), .rst_i(rst), .bus(i4.slave));
  seq_mult_param #(.WIDTH(8))  d8  (.clk_i(clk), .rst_i(rst), .bus(i8.slave));
  seq_mult_param #(.WIDTH(16)) d16 (.clk_i(clk), .rst_i(rst), .bus(i16.slave));
  int checks = 0;
  int passed = 0;
  int failed = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  // Reference: plain integer arithmetic on the operand values each format represents.
  function automatic logic [63:0] model(input int w, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    longint mask = (longint'(1) << (2 * w)) - 1;
    longint ua   = longint'(a) & ((longint'(1) << w) - 1);
    longint ub   = longint'(b) & ((longint'(1) << w) - 1);
    longint half = longint'(1) << (w - 1);
    bit     neg  = (ua >= half) != (ub >= half);
    longint p;
    if (m == 2'b01) begin
      p = (ua % half) * (ub % half);
      if (neg && p != 0) p = p + (longint'(1) << (2 * w - 1));
    end else if (m == 2'b10) p = (ua >= half ? ua - 2 * half : ua) * (ub >= half ? ub - 2 * half : ub);
    else p = ua * ub;
    return 64'(p & mask);
  endfunction
  task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b, input logic [1:0] m, input logic s);
    if (w == 4) begin
      i4.a_bi = a[3:0]; i4.b_bi = b[3:0]; i4.mode_i = m; i4.start_i = s;
    end else if (w == 8) begin
      i8.a_bi = a[7:0]; i8.b_bi = b[7:0]; i8.mode_i = m; i8.start_i = s;
    end else begin
      i16.a_bi = a[15:0]; i16.b_bi = b[15:0]; i16.mode_i = m; i16.start_i = s;
    end
  endtask
  function automatic logic [63:0] get_y(input int w);
    return w == 4 ? 64'(i4.y_bo) : w == 8 ? 64'(i8.y_bo) : 64'(i16.y_bo);
  endfunction
  function automatic logic get_busy(input int w);
    return w == 4 ? i4.busy_o : w == 8 ? i8.busy_o : i16.busy_o;
  endfunction
  function automatic logic get_done(input int w);
    return w == 4 ? i4.done_o : w == 8 ? i8.done_o : i16.done_o;
  endfunction
  function automatic logic [31:0] pick(input int w);
    logic [31:0] mask = (32'd1 << w) - 1;
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return mask;
      3: return 32'd1 << (w - 1);
      default: return $urandom & mask;
    endcase
  endfunction
  // One full operation; operands are scrambled while busy to prove they were latched.
  task automatic run_op(input int w, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                        input string tag, output logic [63:0] y);
    logic [63:0] exp = model(w, m, a, b);
    int  nb  = 0;
    bit  got = 0;
    @(negedge clk);
    drive(w, a, b, m, 1'b1);
    @(negedge clk);
    drive(w, $urandom, $urandom, 2'($urandom), 1'b0);
    for (int c = 0; c < 100 && !got; c++) begin
      if (get_done(w)) got = 1;
      else begin
        if (get_busy(w)) nb++;
        drive(w, $urandom, $urandom, 2'($urandom), 1'b0);
        @(negedge clk);
      end
    end
    check({tag, " done"}, 64'(got), 64'd1);
    check({tag, " busy_cycles"}, 64'(nb), 64'(w));
    check({tag, " busy_at_done"}, 64'(get_busy(w)), 64'd0);
    y = get_y(w);
    check({tag, " y"}, y, exp);
    @(negedge clk);
    check({tag, " done_strobe"}, 64'(get_done(w)), 64'd0);
    check({tag, " y_hold"}, get_y(w), exp);
  endtask
  initial begin
    logic [63:0] y;
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [1:0]  qm[$];
    logic [7:0]  ra, rb, ea, eb;
    logic [1:0]  rm, em;
    int last = -1, cyc = 0, ndone = 0;
    drive(4, 0, 0, 0, 0);
    drive(8, 0, 0, 0, 0);
    drive(16, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset busy", 64'(i8.busy_o), 64'd0);
    check("reset done", 64'(i8.done_o), 64'd0);
    check("reset y", 64'(i8.y_bo), 64'd0);
    rst = 1'b0;
    run_op(8, 2'b00, 32'hFF, 32'hFF, "u ff*ff", y);
    check("u ff*ff const", y, 64'hFE01);
    run_op(8, 2'b10, 32'h80, 32'h80, "tc 80*80", y);
    check("tc 80*80 const", y, 64'h4000);
    run_op(8, 2'b10, 32'h80, 32'h7F, "tc 80*7f", y);
    check("tc 80*7f const", y, 64'hC080);
    run_op(8, 2'b10, 32'hFF, 32'h01, "tc ff*01", y);
    check("tc ff*01 const", y, 64'hFFFF);
    run_op(8, 2'b01, 32'h85, 32'h03, "sm 85*03", y);
    check("sm 85*03 const", y, 64'h800F);
    run_op(8, 2'b01, 32'h80, 32'h05, "sm 80*05", y);
    check("sm 80*05 const", y, 64'h0000);
    run_op(8, 2'b01, 32'hFF, 32'h7F, "sm ff*7f", y);
    check("sm ff*7f const", y, 64'hBF01);
    // start held high: accepts land only on done cycles, period WIDTH+1
    @(negedge clk);
    ra = 8'($urandom); rb = 8'($urandom); rm = 2'($urandom);
    drive(8, ra, rb, rm, 1'b1);
    qa.push_back(ra); qb.push_back(rb); qm.push_back(rm);
    for (int c = 0; c < 200 && ndone < 4; c++) begin
      @(negedge clk);
      cyc++;
      if (i8.done_o) begin
        ea = qa.pop_front(); eb = qb.pop_front(); em = qm.pop_front();
        check("b2b y", 64'(i8.y_bo), model(8, em, ea, eb));
        check("b2b busy_at_done", 64'(i8.busy_o), 64'd0);
        if (last >= 0) check("b2b period", 64'(cyc - last), 64'd9);
        last = cyc;
        ndone++;
      end
      ra = 8'($urandom); rb = 8'($urandom); rm = 2'($urandom);
      if (ndone == 4) drive(8, ra, rb, rm, 1'b0);
      else begin
        drive(8, ra, rb, rm, 1'b1);
        if (i8.done_o) begin
          qa.push_back(ra); qb.push_back(rb); qm.push_back(rm);
        end
      end
    end
    check("b2b count", 64'(ndone), 64'd4);
    @(negedge clk);
    check("b2b idle", 64'(i8.busy_o), 64'd0);
    // reset in WORK cycle 4 abandons the operation
    drive(8, 32'h10, 32'h10, 2'b00, 1'b1);
    @(negedge clk);
    drive(8, 32'h10, 32'h10, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    check("midrst busy_before", 64'(i8.busy_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", 64'(i8.busy_o), 64'd0);
    check("midrst done", 64'(i8.done_o), 64'd0);
    check("midrst y", 64'(i8.y_bo), 64'd0);
    rst = 1'b0;
    run_op(8, 2'b00, 32'h10, 32'h10, "post_rst", y);
    check("post_rst const", y, 64'h0100);
    for (int n = 0; n < 1000; n++) run_op(4, 2'($urandom), pick(4), pick(4), "rand4", y);
    for (int n = 0; n < 1000; n++) run_op(16, 2'($urandom), pick(16), pick(16), "rand16", y);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
Parametrised iterative shift-add multiplier for the arithmetic datapath. It accepts two WIDTH-bit operands on a start pulse and processes one multiplier bit per clock. It returns a 2*WIDTH-bit product with a one-cycle done strobe. Three operand formats are selectable per operation: unsigned, sign-magnitude and two's complement.

Parameters:
WIDTH  8  operand width in bits; legal range 2..32; product width is 2*WIDTH

Ports:
clk_i     in   1          clock; all logic on rising edge
rst_i     in   1          synchronous reset, active-high
a_bi      in   WIDTH      operand A (multiplicand)
b_bi      in   WIDTH      operand B (multiplier)
mode_i    in   2          format: 00 unsigned, 01 sign-magnitude, 10 two's complement, 11 treated as 00
start_i   in   1          request; sampled only while idle
busy_o    out  1          high while an operation is in progress
done_o    out  1          one-cycle strobe: y_bo updated this cycle
y_bo      out  2*WIDTH    product; holds its value until the next done_o

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset (rst_i=1 at an edge): state=IDLE, counter=0, accumulator=0, busy_o=0, done_o=0, y_bo=0. Reset has priority over everything else.
- Reset mid-operation: the operation is abandoned, no done_o is produced and y_bo=0.
- States:
  - IDLE: busy_o=0. On an edge with start_i=1, latch a_bi, b_bi and mode_i, precompute magnitudes and the result sign, clear accumulator and counter, and go to WORK. start_i=0 keeps the block in IDLE.
  - WORK: busy_o=1. Each edge adds (magA AND replicate(magB[ctr])) << ctr into the accumulator and increments ctr. On the edge where ctr==WIDTH-1, also write the final result to y_bo, pulse done_o=1, clear busy_o and return to IDLE.
- Latency: start accepted at edge T. busy_o=1 for exactly WIDTH cycles, from T+1 through T+WIDTH. y_bo valid and done_o=1 in the cycle after edge T+WIDTH. The latency is fixed and independent of operand values.
- start_i during WORK is ignored, with no queuing. start_i in the done_o cycle is accepted, since the block is already in IDLE, giving back-to-back operations with no dead cycle.
- Operands and mode are latched at accept; changes on a_bi, b_bi or mode_i during WORK have no effect.
- done_o is never high at the same time as busy_o.
- Arithmetic per mode:
  - Unsigned: magA=a, magB=b, sign=0, y = magA*magB.
  - Sign-magnitude: magnitudes are the low WIDTH-1 bits, each zero-extended; sign = a[MSB] XOR b[MSB]. Result is {sign, 1'b0, product[2*WIDTH-3:0]}.
    - Negative zero is normalised: if the product is 0, the output sign bit is 0.
    - An operand of -0 is treated as 0.
  - Two's complement: magX = |X| as an unsigned WIDTH-bit value; |-2^(WIDTH-1)| = 2^(WIDTH-1) is representable. sign = a[MSB] XOR b[MSB]. y = sign ? -(magA*magB) : magA*magB in 2*WIDTH bits.
    - The extreme case (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) fits as a positive value.
    - A zero product always gives y=0.
- Accumulator width is 2*WIDTH. There is no overflow in any mode.
- Counter width is clog2(WIDTH)+1. It does not wrap during an operation.

Test Plan:
- WIDTH=8, mode=00, a=0xFF, b=0xFF, start pulse -> busy_o high exactly 8 cycles, then done_o=1 with y_bo=0xFE01; y_bo holds 0xFE01 afterwards.
- mode=10: (a=0x80, b=0x80) -> y_bo=0x4000; (a=0x80, b=0x7F) -> y_bo=0xC080; (a=0xFF, b=0x01) -> y_bo=0xFFFF.
- mode=01: (a=0x85, b=0x03) -> y_bo=0x800F; (a=0x80, b=0x05) -> y_bo=0x0000 (normalised zero); (a=0xFF, b=0x7F) -> y_bo=0xBF01.
- start_i held high continuously with a,b changing each cycle -> operations are accepted only in the done_o cycles, back-to-back with a period of WIDTH+1 cycles; each result matches the operands latched at its accept edge.
- Assert rst_i at WORK cycle 4 of an operation (mode=00, a=0x10, b=0x10) -> next cycle busy_o=0, done_o=0, y_bo=0. A fresh start then yields the correct product 0x0100 with no residue.
- Randomised check, WIDTH=4 and WIDTH=16, all modes, 1000 operations each against a reference model. Includes the extreme operands 0, 1, all-ones and most-negative.
